fc_port_state_ctrl: RTL and testbench

FC_PORT_STATE_CTRL -- requirements
Module: fc_port_state_ctrl

---
 rtl/fc_port_state_ctrl_pkg.sv | 96 +++++++++
 rtl/fc_port_state_ctrl_timer.sv | 37 +++
 rtl/fc_port_state_ctrl.sv | 109 ++++++++++
 tb/tb_fc_port_state_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_port_state_ctrl_pkg.sv
// Shared Fibre Channel port definitions: port states, received primitive
// sequences, default timeouts and the primitive-sequence transition table.
package fc;

  typedef enum logic [3:0] {
    STATE_AC,
    STATE_LR1,
    STATE_LR2,
    STATE_LR3,
    STATE_LF1,
    STATE_LF2,
    STATE_OL1,
    STATE_OL2,
    STATE_OL3
  } state_t;

  typedef enum logic [2:0] {
    PS_NONE,
    PS_IDLE,
    PS_LR,
    PS_LRR,
    PS_NOS,
    PS_OLS
  } ps_t;

  // 100 ms and 5 ms at a 100 MHz clock
  localparam int unsigned TOV_CYCLES_DEFAULT    = 10000000;
  localparam int unsigned OL_MIN_CYCLES_DEFAULT = 500000;

  // Target state for a qualified received primitive sequence; returns the
  // current state when the sequence has no effect there (OL1 ignores all).
  function automatic state_t ps_next(state_t s, ps_t ps);
    state_t r;
    r = s;
    case (s)
      STATE_AC, STATE_LR1: begin
        case (ps)
          PS_LR:   r = STATE_LR2;
          PS_LRR:  r = STATE_LR3;
          PS_NOS:  r = STATE_LF2;
          PS_OLS:  r = STATE_OL2;
          default: r = s;
        endcase
      end
      STATE_LR2: begin
        case (ps)
          PS_LRR:  r = STATE_LR3;
          PS_NOS:  r = STATE_LF2;
          PS_OLS:  r = STATE_OL2;
          default: r = s;
        endcase
      end
      STATE_LR3: begin
        case (ps)
          PS_IDLE: r = STATE_AC;
          PS_LR:   r = STATE_LR2;
          PS_NOS:  r = STATE_LF2;
          PS_OLS:  r = STATE_OL2;
          default: r = s;
        endcase
      end
      STATE_LF1: begin
        case (ps)
          PS_NOS:  r = STATE_LF2;
          PS_OLS:  r = STATE_OL2;
          default: r = s;
        endcase
      end
      STATE_LF2: begin
        case (ps)
          PS_LR:   r = STATE_LR2;
          PS_OLS:  r = STATE_OL2;
          default: r = s;
        endcase
      end
      STATE_OL2: begin
        case (ps)
          PS_LR:   r = STATE_OL3;
          PS_NOS:  r = STATE_LF2;
          default: r = s;
        endcase
      end
      STATE_OL3: begin
        case (ps)
          PS_LRR:  r = STATE_LR3;
          PS_OLS:  r = STATE_OL2;
          PS_NOS:  r = STATE_LF2;
          default: r = s;
        endcase
      end
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fc_port_state_ctrl_timer.sv
// Saturating cycle timer with synchronous clear and a terminal-count flag.
module fc_tov_timer #(
  parameter int unsigned W         = 24,
  parameter int unsigned MAX_COUNT = 10000000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d, inc;

  // Increment saturates at MAX_COUNT. The flag looks at the incremented value
  // (not cnt_d) so it fires on the edge where the count reaches term_i and does
  // not depend on clr_i, which the parent derives from this flag.
  always_comb begin
    inc = cnt_q;
    if (en_i && (cnt_q < W'(MAX_COUNT))) begin
      inc = cnt_q + W'(1);
    end
    cnt_d = clr_i ? '0 : inc;
    tc_o  = en_i && (inc >= term_i);
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fc_port_state_ctrl.sv
// FC port state machine: link recovery, link failure and offline handling
// driven by received primitive sequences, sync status and host requests.
module fc_port_state_ctrl
  import fc::*;
#(
  parameter int unsigned TOV_CYCLES    = fc::TOV_CYCLES_DEFAULT,
  parameter int unsigned OL_MIN_CYCLES = fc::OL_MIN_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  ps_t         rx_ps,
  input  logic        rx_ps_valid,
  input  logic        rx_sync,
  input  logic        offline_req,
  input  logic        lr_req,
  output state_t      state,
  output logic        active,
  output logic        state_change,
  output logic [15:0] lr_count
);

  localparam int unsigned MAX_CYCLES = (TOV_CYCLES > OL_MIN_CYCLES) ? TOV_CYCLES : OL_MIN_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  state_t             state_q, state_d, ps_tgt;
  logic               chg_q, chg_d;
  logic [15:0]        lrc_q, lrc_d;
  logic               ps_ev, st_en, st_clr, st_tc, sync_tc;
  logic [CNT_W-1:0]   st_term;

  // State timer runs in the recovery states and OL1; OL1 uses the hold limit.
  always_comb begin
    st_en   = state_q inside {STATE_LR1, STATE_LR2, STATE_LR3, STATE_OL1};
    st_term = (state_q == STATE_OL1) ? CNT_W'(OL_MIN_CYCLES) : CNT_W'(TOV_CYCLES);
    st_clr  = (state_d != state_q);
  end

  fc_tov_timer #(
    .W         (CNT_W),
    .MAX_COUNT (MAX_CYCLES)
  ) u_state_timer (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (st_clr),
    .en_i   (st_en),
    .term_i (st_term),
    .tc_o   (st_tc)
  );

  fc_tov_timer #(
    .W         (CNT_W),
    .MAX_COUNT (MAX_CYCLES)
  ) u_sync_timer (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (rx_sync),
    .en_i   (!rx_sync),
    .term_i (CNT_W'(TOV_CYCLES)),
    .tc_o   (sync_tc)
  );

  // Next state in priority order: sync loss, state timeout / OL1 hold,
  // primitive sequence, offline request, link-reset request.
  always_comb begin
    state_d = state_q;
    ps_ev   = rx_ps_valid && (rx_ps != PS_NONE);
    ps_tgt  = ps_next(state_q, rx_ps);
    if (sync_tc && !(state_q inside {STATE_LF1, STATE_OL1})) begin
      state_d = STATE_LF1;
    end else if (state_q == STATE_OL1) begin
      if (st_tc && !offline_req) begin
        state_d = STATE_LR1;
      end
    end else if (st_tc) begin
      state_d = STATE_LF1;
    end else if (ps_ev && (ps_tgt != state_q)) begin
      state_d = ps_tgt;
    end else if ((state_q == STATE_AC) && offline_req) begin
      state_d = STATE_OL1;
    end else if ((state_q == STATE_AC) && lr_req) begin
      state_d = STATE_LR1;
    end

    chg_d = (state_d != state_q);
    lrc_d = lrc_q;
    if ((state_q == STATE_AC) && (state_d inside {STATE_LR1, STATE_LR2}) && (lrc_q != '1)) begin
      lrc_d = lrc_q + 16'd1;
    end
  end

  // State, change pulse and link-recovery counter registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= STATE_OL1;
      chg_q   <= 1'b0;
      lrc_q   <= '0;
    end else begin
      state_q <= state_d;
      chg_q   <= chg_d;
      lrc_q   <= lrc_d;
    end
  end

  assign state        = state_q;
  assign active       = (state_q == STATE_AC);
  assign state_change = chg_q;
  assign lr_count     = lrc_q;

endmodule

// File: tb/tb_fc_port_state_ctrl.sv
// Bench for fc_port_state_ctrl: directed vector table, hand-written corner
// sequences, and random stimulus against a cycle-count reference model.
module tb_fc_port_state_ctrl;
  import fc::*;

  localparam int TOV = 16;
  localparam int OLM = 8;

  logic        clk;
  logic        reset_n;
  ps_t         rx_ps;
  logic        rx_ps_valid;
  logic        rx_sync;
  logic        offline_req;
  logic        lr_req;
  state_t      state;
  logic        active;
  logic        state_change;
  logic [15:0] lr_count;

  int total = 0;
  int bad   = 0;

  fc_port_state_ctrl #(
    .TOV_CYCLES    (TOV),
    .OL_MIN_CYCLES (OLM)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_ps        (rx_ps),
    .rx_ps_valid  (rx_ps_valid),
    .rx_sync      (rx_sync),
    .offline_req  (offline_req),
    .lr_req       (lr_req),
    .state        (state),
    .active       (active),
    .state_change (state_change),
    .lr_count     (lr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  // Reference model: transition table plus elapsed-cycle counts in plain ints
  state_t mt [0:8][0:5];
  state_t m_state = STATE_OL1;
  int     m_time  = 0;
  int     m_low   = 0;
  int     m_lrc   = 0;
  bit     m_chg   = 1'b0;

  task automatic setn(input state_t s, input ps_t p, input state_t n);
    mt[int'(s)][int'(p)] = n;
  endtask

  task automatic init_tbl();
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 6; j++)
        mt[i][j] = state_t'(i);
    setn(STATE_AC,  PS_LR,  STATE_LR2); setn(STATE_AC,  PS_LRR, STATE_LR3);
    setn(STATE_AC,  PS_NOS, STATE_LF2); setn(STATE_AC,  PS_OLS, STATE_OL2);
    setn(STATE_LR1, PS_LR,  STATE_LR2); setn(STATE_LR1, PS_LRR, STATE_LR3);
    setn(STATE_LR1, PS_NOS, STATE_LF2); setn(STATE_LR1, PS_OLS, STATE_OL2);
    setn(STATE_LR2, PS_LRR, STATE_LR3); setn(STATE_LR2, PS_NOS, STATE_LF2);
    setn(STATE_LR2, PS_OLS, STATE_OL2);
    setn(STATE_LR3, PS_IDLE, STATE_AC); setn(STATE_LR3, PS_LR,  STATE_LR2);
    setn(STATE_LR3, PS_NOS, STATE_LF2); setn(STATE_LR3, PS_OLS, STATE_OL2);
    setn(STATE_LF1, PS_NOS, STATE_LF2); setn(STATE_LF1, PS_OLS, STATE_OL2);
    setn(STATE_LF2, PS_LR,  STATE_LR2); setn(STATE_LF2, PS_OLS, STATE_OL2);
    setn(STATE_OL2, PS_LR,  STATE_OL3); setn(STATE_OL2, PS_NOS, STATE_LF2);
    setn(STATE_OL3, PS_LRR, STATE_LR3); setn(STATE_OL3, PS_OLS, STATE_OL2);
    setn(STATE_OL3, PS_NOS, STATE_LF2);
  endtask

  task automatic model_step();
    state_t nxt;
    int     elapsed;
    bit     ev;
    if (!reset_n) begin
      m_state = STATE_OL1; m_time = 0; m_low = 0; m_lrc = 0; m_chg = 1'b0;
      return;
    end
    elapsed = (m_state inside {STATE_LR1, STATE_LR2, STATE_LR3, STATE_OL1}) ? m_time + 1 : 0;
    ev  = rx_ps_valid && (rx_ps != PS_NONE);
    nxt = m_state;
    if (!rx_sync && (m_low + 1 >= TOV) && !(m_state inside {STATE_LF1, STATE_OL1}))
      nxt = STATE_LF1;
    else if (m_state == STATE_OL1) begin
      if (elapsed >= OLM && !offline_req) nxt = STATE_LR1;
    end else if ((m_state inside {STATE_LR1, STATE_LR2, STATE_LR3}) && elapsed >= TOV)
      nxt = STATE_LF1;
    else if (ev && (mt[int'(m_state)][int'(rx_ps)] != m_state))
      nxt = mt[int'(m_state)][int'(rx_ps)];
    else if (m_state == STATE_AC && offline_req)
      nxt = STATE_OL1;
    else if (m_state == STATE_AC && lr_req)
      nxt = STATE_LR1;
    if (m_state == STATE_AC && (nxt inside {STATE_LR1, STATE_LR2}) && m_lrc < 65535)
      m_lrc++;
    m_chg   = (nxt != m_state);
    m_time  = m_chg ? 0 : elapsed;
    m_low   = rx_sync ? 0 : m_low + 1;
    m_state = nxt;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset_n = 1'b1; rx_ps = PS_NONE; rx_ps_valid = 1'b0;
    rx_sync = 1'b1; offline_req = 1'b0; lr_req = 1'b0;
  endtask

  task automatic reach_ac(input string nm);
    idle_inputs();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    repeat (OLM) tick();
    rx_ps = PS_LRR; rx_ps_valid = 1'b1; tick();
    rx_ps = PS_IDLE; tick();
    idle_inputs();
    check({nm, " reach AC"}, state, STATE_AC);
  endtask

  typedef struct {
    logic        rst_n;
    ps_t         ps;
    logic        vld;
    logic        sync;
    logic        off;
    logic        lr;
    int unsigned n;
    state_t      st;
    logic        chg;
    logic [15:0] lrc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, ps_t p, logic v, logic s, logic o, logic l,
                              int unsigned n, state_t st, logic c, logic [15:0] lc);
    vec_t x;
    x.rst_n = r; x.ps = p; x.vld = v; x.sync = s; x.off = o; x.lr = l;
    x.n = n; x.st = st; x.chg = c; x.lrc = lc;
    return x;
  endfunction

  int unsigned sync_low_left;
  int unsigned off_left;

  initial begin
    init_tbl();
    idle_inputs();
    reset_n = 1'b0;

    //            rst ps       vld sync off lr  n   state      chg lrc
    vt.push_back(mk(0, PS_NONE, 0, 1, 0, 0,  1, STATE_OL1, 0, 0));
    vt.push_back(mk(1, PS_OLS,  1, 1, 0, 0,  7, STATE_OL1, 0, 0));
    vt.push_back(mk(1, PS_NONE, 0, 1, 0, 0,  1, STATE_LR1, 1, 0));
    vt.push_back(mk(1, PS_LRR,  1, 1, 0, 0,  1, STATE_LR3, 1, 0));
    vt.push_back(mk(1, PS_IDLE, 1, 1, 0, 0,  1, STATE_AC,  1, 0));
    vt.push_back(mk(1, PS_NONE, 0, 1, 0, 0,  3, STATE_AC,  0, 0));
    vt.push_back(mk(1, PS_NOS,  0, 1, 0, 0,  1, STATE_AC,  0, 0));
    vt.push_back(mk(1, PS_LR,   1, 1, 0, 0,  1, STATE_LR2, 1, 1));
    vt.push_back(mk(1, PS_NONE, 0, 1, 0, 0, 15, STATE_LR2, 0, 1));
    vt.push_back(mk(1, PS_NONE, 0, 1, 0, 0,  1, STATE_LF1, 1, 1));
    vt.push_back(mk(1, PS_NOS,  1, 1, 0, 0,  1, STATE_LF2, 1, 1));
    vt.push_back(mk(1, PS_LR,   1, 1, 0, 0,  1, STATE_LR2, 1, 1));
    vt.push_back(mk(1, PS_LRR,  1, 1, 0, 0,  1, STATE_LR3, 1, 1));
    vt.push_back(mk(1, PS_IDLE, 1, 1, 0, 0,  1, STATE_AC,  1, 1));
    vt.push_back(mk(1, PS_NONE, 0, 0, 0, 0, 15, STATE_AC,  0, 1));
    vt.push_back(mk(1, PS_NONE, 0, 0, 0, 0,  1, STATE_LF1, 1, 1));
    vt.push_back(mk(1, PS_OLS,  1, 1, 0, 0,  1, STATE_OL2, 1, 1));
    vt.push_back(mk(1, PS_LR,   1, 1, 0, 0,  1, STATE_OL3, 1, 1));
    vt.push_back(mk(1, PS_LRR,  1, 1, 0, 0,  1, STATE_LR3, 1, 1));
    vt.push_back(mk(1, PS_IDLE, 1, 1, 0, 0,  1, STATE_AC,  1, 1));
    vt.push_back(mk(1, PS_NONE, 0, 1, 1, 1,  1, STATE_OL1, 1, 1));
    vt.push_back(mk(1, PS_NONE, 0, 1, 1, 0, 12, STATE_OL1, 0, 1));
    vt.push_back(mk(1, PS_NONE, 0, 1, 0, 0,  1, STATE_LR1, 1, 1));
    vt.push_back(mk(1, PS_LRR,  1, 1, 0, 0,  1, STATE_LR3, 1, 1));
    vt.push_back(mk(1, PS_IDLE, 1, 1, 0, 0,  1, STATE_AC,  1, 1));
    vt.push_back(mk(1, PS_NONE, 0, 1, 0, 1,  1, STATE_LR1, 1, 2));
    vt.push_back(mk(1, PS_LR,   1, 1, 0, 0,  1, STATE_LR2, 1, 2));
    vt.push_back(mk(0, PS_NONE, 0, 1, 0, 0,  1, STATE_OL1, 0, 0));
    vt.push_back(mk(1, PS_NONE, 0, 1, 0, 0,  1, STATE_OL1, 0, 0));
    vt.push_back(mk(1, PS_NONE, 0, 1, 0, 0,  6, STATE_OL1, 0, 0));
    vt.push_back(mk(1, PS_NONE, 0, 1, 0, 0,  1, STATE_LR1, 1, 0));

    foreach (vt[i]) begin
      reset_n = vt[i].rst_n; rx_ps = vt[i].ps; rx_ps_valid = vt[i].vld;
      rx_sync = vt[i].sync; offline_req = vt[i].off; lr_req = vt[i].lr;
      repeat (vt[i].n) tick();
      check($sformatf("vec%0d state", i), state, vt[i].st);
      check($sformatf("vec%0d active", i), active, (vt[i].st == STATE_AC));
      check($sformatf("vec%0d state_change", i), state_change, vt[i].chg);
      check($sformatf("vec%0d lr_count", i), lr_count, vt[i].lrc);
    end

    // Sync-loss terminal count beats a simultaneous NOS in LR1
    reach_ac("syncpri");
    lr_req = 1'b1; rx_sync = 1'b0; tick();
    lr_req = 1'b0;
    check("syncpri enter LR1", state, STATE_LR1);
    repeat (14) tick();
    check("syncpri hold LR1", state, STATE_LR1);
    rx_ps = PS_NOS; rx_ps_valid = 1'b1; tick();
    check("syncpri LF1 not LF2", state, STATE_LF1);

    // State timeout beats a simultaneous NOS in LR1
    reach_ac("tmopri");
    lr_req = 1'b1; tick();
    lr_req = 1'b0;
    repeat (15) tick();
    check("tmopri hold LR1", state, STATE_LR1);
    rx_ps = PS_NOS; rx_ps_valid = 1'b1; tick();
    check("tmopri LF1 not LF2", state, STATE_LF1);

    // Primitive sequence beats offline_req in AC
    reach_ac("pspri");
    rx_ps = PS_LR; rx_ps_valid = 1'b1; offline_req = 1'b1; tick();
    check("pspri LR2 not OL1", state, STATE_LR2);
    check("pspri lr_count", lr_count, 1);

    // Random stimulus against the reference model
    idle_inputs();
    sync_low_left = 0;
    off_left = 0;
    for (int c = 0; c < 4000; c++) begin
      reset_n     = ($urandom_range(0, 299) != 0);
      rx_ps       = ps_t'($urandom_range(0, 5));
      rx_ps_valid = ($urandom_range(0, 7) == 0);
      if (sync_low_left == 0 && $urandom_range(0, 79) == 0)
        sync_low_left = $urandom_range(4, 24);
      rx_sync = (sync_low_left == 0);
      if (sync_low_left != 0) sync_low_left--;
      if (off_left == 0 && $urandom_range(0, 59) == 0)
        off_left = $urandom_range(1, 20);
      offline_req = (off_left != 0);
      if (off_left != 0) off_left--;
      lr_req = ($urandom_range(0, 29) == 0);
      tick();
      check($sformatf("rnd%0d state", c), state, m_state);
      check($sformatf("rnd%0d active", c), active, (m_state == STATE_AC));
      check($sformatf("rnd%0d state_change", c), state_change, m_chg);
      check($sformatf("rnd%0d lr_count", c), lr_count, m_lrc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
